// File: rtl/serial_mag_comparator.sv
// serial_mag_comparator: bit-serial unsigned magnitude comparator.
// Operands are captured on start, then walked MSB-first one bit per clock.
// The first differing bit decides lesser/greater; if every bit matches the
// result is equal. The result holds until the next comparison is accepted.
// Optional feature macro: SERIAL_CMP_EARLY_EXIT_EN. When defined, the walk
// stops on the first differing bit. Otherwise all n bits are consumed.
// The lesser/greater/equal outcome is the same in both builds.
module serial_mag_comparator #(
  parameter int n = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         lesser,
  output logic         greater,
  output logic         equal
);

  // Counter wide enough to hold n-1; n >= 2 guarantees at least one bit.
  localparam int CW = (n > 2) ? $clog2(n) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(n - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [n-1:0]  a_sh_q, a_sh_d;
  logic [n-1:0]  b_sh_q, b_sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          lesser_q, lesser_d;
  logic          greater_q, greater_d;
  logic          equal_q, equal_d;
  logic          a_msb_s;
  logic          b_msb_s;
  logic          decided_s;

  // Next-state, datapath and registered-output computation for the FSM.
  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    cnt_d     = cnt_q;
    lesser_d  = lesser_q;
    greater_d = greater_q;
    equal_d   = equal_q;
    a_msb_s   = a_sh_q[n-1];
    b_msb_s   = b_sh_q[n-1];
    decided_s = lesser_q | greater_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SHIFT;
          a_sh_d    = a;
          b_sh_d    = b;
          cnt_d     = CNT_INIT;
          lesser_d  = 1'b0;
          greater_d = 1'b0;
          equal_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        a_sh_d = {a_sh_q[n-2:0], 1'b0};
        b_sh_d = {b_sh_q[n-2:0], 1'b0};

        // Only the first differing pair may set a result bit.
        if (!decided_s && a_msb_s && !b_msb_s) begin
          greater_d = 1'b1;
        end else if (!decided_s && !a_msb_s && b_msb_s) begin
          lesser_d = 1'b1;
        end else begin
          greater_d = greater_q;
        end

        if (cnt_q == CNT_ZERO) begin
          // Last pair compared: the counter stops here rather than wrapping.
          state_d = DONE;
          if (!lesser_d && !greater_d) begin
            equal_d = 1'b1;
          end else begin
            equal_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
          if (!decided_s && (a_msb_s != b_msb_s)) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
`else
          state_d = SHIFT;
`endif
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_sh_q    <= {n{1'b0}};
      b_sh_q    <= {n{1'b0}};
      cnt_q     <= CNT_ZERO;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      lesser_q  <= 1'b0;
      greater_q <= 1'b0;
      equal_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      lesser_q  <= lesser_d;
      greater_q <= greater_d;
      equal_q   <= equal_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign lesser  = lesser_q;
  assign greater = greater_q;
  assign equal   = equal_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Self-checking bench for serial_mag_comparator (n = 16).
// Uses directed vectors, multi-cycle corner sequences and random operands.
// Build-aware: latency expectations follow SERIAL_CMP_EARLY_EXIT_EN.
module tb_serial_mag_comparator;

  localparam int N     = 16;
  localparam int LIMIT = 60;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] a_in;
  logic [N-1:0] b_in;
  logic         busy;
  logic         done;
  logic         lesser;
  logic         greater;
  logic         equal;

  int errors;
  int checks;

  serial_mag_comparator #(.n(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a_in),
    .b       (b_in),
    .busy    (busy),
    .done    (done),
    .lesser  (lesser),
    .greater (greater),
    .equal   (equal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   res;     // {lesser, greater, equal}
    int           lat_ee;  // cycles E0->done, early-exit build
    int           lat_ne;  // cycles E0->done, full-walk build
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference model: expected result from plain arithmetic comparison.
  function automatic logic [2:0] model_res(input logic [N-1:0] x, input logic [N-1:0] y);
    return {(x < y), (x > y), (x == y)};
  endfunction

  // Reference model: expected latency from the position of the first differing bit.
  function automatic int model_lat(input logic [N-1:0] x, input logic [N-1:0] y);
    int first_diff_from_msb;
    first_diff_from_msb = N - 1;
    for (int i = 0; i < N; i++) begin
      if (x[N-1-i] != y[N-1-i]) begin
        first_diff_from_msb = i;
        break;
      end
    end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    return first_diff_from_msb + 1;
`else
    return (first_diff_from_msb >= 0) ? N : N;
`endif
  endfunction

  // Wait for done; lat = cycles after E0, busy_cnt = cycles busy was seen.
  task automatic collect(output int lat, output int busy_cnt, output logic [2:0] res,
                         output int onehot);
    lat = -1;
    busy_cnt = 0;
    res = 3'b000;
    onehot = 0;
    for (int k = 1; k <= LIMIT; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k - 1;
        res = {lesser, greater, equal};
        onehot = int'(lesser) + int'(greater) + int'(equal);
        break;
      end
      if (busy) busy_cnt++;
    end
    if (lat < 0) begin
      errors++;
      checks++;
      $display("FAIL timeout: got=no_done expected=done_within_%0d", LIMIT);
    end
  endtask

  // Full comparison starting from a negedge in IDLE; checks result, timing, hold.
  task automatic run_op(input string name, input logic [N-1:0] av, input logic [N-1:0] bv,
                        input logic [2:0] exp_res, input int exp_lat);
    int lat;
    int bc;
    int oh;
    logic [2:0] res;
    start = 1'b1;
    a_in  = av;
    b_in  = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in  = N'($urandom);
    b_in  = N'($urandom);
    collect(lat, bc, res, oh);
    check({name, "_result"}, int'(res), int'(exp_res));
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_busy_cycles"}, bc, exp_lat);
    check({name, "_onehot"}, oh, 1);
    @(negedge clk);
    check({name, "_done_one_cycle"}, int'({busy, done}), 0);
    check({name, "_hold"}, int'({lesser, greater, equal}), int'(exp_res));
  endtask

  initial begin
    int lat;
    int bc;
    int oh;
    int seen_done;
    logic [2:0] res;
    logic [N-1:0] ra;
    logic [N-1:0] rb;

    errors = 0;
    checks = 0;

    vecs[0] = '{16'h8000, 16'h7FFF, 3'b010, 1, 16};
    vecs[1] = '{16'hA5A5, 16'hA5A5, 3'b001, 16, 16};
    vecs[2] = '{16'h0001, 16'h0002, 3'b100, 15, 16};
    vecs[3] = '{16'h0000, 16'h0000, 3'b001, 16, 16};
    vecs[4] = '{16'hFFFF, 16'h0000, 3'b010, 1, 16};
    vecs[5] = '{16'h0000, 16'hFFFF, 3'b100, 1, 16};
    vecs[6] = '{16'h1234, 16'h1235, 3'b100, 16, 16};
    vecs[7] = '{16'h7FFF, 16'h7FFE, 3'b010, 16, 16};
    vecs[8] = '{16'h4000, 16'h0000, 3'b010, 2, 16};

    // Reset state, with start asserted to show reset wins.
    rst   = 1'b1;
    start = 1'b1;
    a_in  = 16'h1111;
    b_in  = 16'h2222;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({busy, done, lesser, greater, equal}), 0);

    // Release reset and start on the same cycle: first edge accepts.
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
`ifdef SERIAL_CMP_EARLY_EXIT_EN
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat_ee);
`else
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat_ne);
`endif
    end

    // Start held high; operands change after acceptance; restart only after IDLE.
    start = 1'b1;
    a_in  = 16'h8000;
    b_in  = 16'h7FFF;
    @(posedge clk);
    #1;
    a_in = 16'h0000;
    b_in = 16'hFFFF;
    collect(lat, bc, res, oh);
    check("held_start_result", int'(res), 3'b010);
    check("held_start_latency", lat, model_lat(16'h8000, 16'h7FFF));
    @(negedge clk);
    check("held_start_idle_gap", int'({busy, done}), 0);
    check("held_start_hold", int'({lesser, greater, equal}), 3'b010);
    collect(lat, bc, res, oh);
    start = 1'b0;
    check("held_start_second_result", int'(res), 3'b100);
    check("held_start_second_latency", lat, model_lat(16'h0000, 16'hFFFF));
    @(negedge clk);

    // Reset five cycles into a comparison aborts it with no done pulse.
    start = 1'b1;
    a_in  = 16'hA5A5;
    b_in  = 16'hA5A5;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_busy_before_rst", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_outputs_cleared", int'({busy, done, lesser, greater, equal}), 0);
    rst = 1'b0;
    seen_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    check("abort_no_done", seen_done, 0);
    run_op("after_abort", 16'hFFFF, 16'h0000, 3'b010, model_lat(16'hFFFF, 16'h0000));

    // Random operands against the reference model.
    for (int r = 0; r < 40; r++) begin
      ra = N'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (N'(1) << $urandom_range(0, N - 1));
        default: rb = N'($urandom);
      endcase
      run_op($sformatf("rand%0d", r), ra, rb, model_res(ra, rb), model_lat(ra, rb));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_mag_comparator.md
SERIAL_MAG_COMPARATOR -- requirements
Module: serial_mag_comparator

Interface
REQ-001 Parameter: n, default 16, operand width in bits; legal range n >= 2.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  request to begin a comparison of a and b.
REQ-005 a  input  n  unsigned operand A, sampled only on start acceptance.
REQ-006 b  input  n  unsigned operand B, sampled only on start acceptance.
REQ-007 busy  output  1  high while a comparison is in progress (SHIFT state).
REQ-008 done  output  1  one-cycle pulse, result valid (DONE state).
REQ-009 lesser  output  1  captured A < B.
REQ-010 greater  output  1  captured A > B.
REQ-011 equal  output  1  captured A == B.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE, with transitions IDLE->SHIFT on start, SHIFT->DONE on decision, and DONE->IDLE unconditionally.
REQ-013 The block SHALL accept start only in IDLE; start in SHIFT or DONE SHALL be ignored with no effect on state or results.
REQ-014 On acceptance (edge E0), the block SHALL load a and b into internal shift registers, load a bit counter with n-1, clear lesser/greater/equal to 0, and enter SHIFT.
REQ-015 Each SHIFT edge SHALL compare the current MSBs of both shift registers, shift both left by one, and decrement the counter.
REQ-016 The block SHALL set greater=1 on the first compared pair with A bit 1 / B bit 0, set lesser=1 on the first pair with A bit 0 / B bit 1, and set equal=1 if all n pairs match.
REQ-017 After a result bit is set, no later compared pair SHALL alter lesser/greater/equal.
REQ-018 Exactly one of lesser/greater/equal SHALL be high while done=1.
REQ-019 The block SHALL assert busy=1 in SHIFT only and done=1 in DONE only; done SHALL last exactly one cycle.
REQ-020 Result outputs SHALL hold their values from DONE through IDLE until the next start is accepted.
REQ-021 Latency without early exit: done SHALL be high in the cycle after edge En, i.e. n cycles after E0, for all operands.
REQ-022 Counter boundary: when the counter is 0 in SHIFT, that edge SHALL be the last compare and SHALL transition to DONE; the counter SHALL never wrap.

Reset
REQ-023 rst=1 at any edge SHALL force IDLE and set busy=0, done=0, lesser=0, greater=0 and equal=0.
REQ-024 rst=1 SHALL clear the shift registers and the counter to 0.
REQ-025 rst=1 mid-SHIFT or in DONE SHALL abort the comparison with no result or done pulse.
REQ-026 rst SHALL take priority over a simultaneous start.
REQ-027 The first start SHALL be accepted on the first edge after rst deasserts.

Configuration
REQ-028 Macro SERIAL_CMP_EARLY_EXIT_EN: when defined, SHIFT SHALL move to DONE on the edge that finds the first differing pair, giving a latency of j+1 cycles after E0 (j = 0-based index from the MSB of the first differing bit); equal operands SHALL still take n cycles.
REQ-029 When SERIAL_CMP_EARLY_EXIT_EN is undefined, SHIFT SHALL always consume all n bits per REQ-021, and the result values SHALL be identical to the defined build.

Verification (n=16)
REQ-030 a=16'h8000, b=16'h7FFF, start pulse -> greater=1, lesser=0, equal=0; done 1 cycle after E0 with macro, 16 cycles after E0 without.
REQ-031 a=b=16'hA5A5 -> equal=1; done 16 cycles after E0 in both builds; busy high for exactly 16 cycles.
REQ-032 a=16'h0001, b=16'h0002 -> lesser=1; done 15 cycles after E0 with macro, 16 cycles after E0 without.
REQ-033 start held high throughout, operands changed to a=0, b=16'hFFFF after E0 -> result reflects the first operands; the next start is accepted only on the edge after the DONE cycle.
REQ-034 rst pulsed 5 cycles after E0 -> next cycle busy=0, done=0, all results 0, and no done pulse; then a=16'hFFFF, b=0 -> greater=1 with normal latency.
